// File: rtl/img_sequencer.sv
// img_sequencer
// Runs one image job against the image controller. It toggles the capture
// command, waits for the capture-done toggle and checks the reported pixel
// count, then toggles the readout command and meters a fixed number of
// readout words downstream under backpressure.
//
// Ports:
//   clk, rst                      image clock, async active-high reset
//   req_valid/req_ready           job handshake (ready only in IDLE)
//   req_capture/readout/thumb     job options, latched on accept
//   cmd_capture/cmd_readout       toggle-style commands to the controller
//   cmd_thumb                     thumbnail select, stable through readout
//   status_captureDone            toggles once per completed capture
//   status_capturePixelCount      pixel count of the last capture
//   readout_ready/trigger/data    controller word stream
//   out_valid/out_ready/out_data  downstream word stream
//   done, err                     end-of-job pulse and result code
module img_sequencer #(
  parameter int FullWordCount   = 4096,
  parameter int ThumbWordCount  = 1024,
  parameter int PixelCount      = 2304,
  parameter int PixelCountWidth = 22,
  parameter int CaptureTimeout  = 1 << 24,
  parameter int WordTimeout     = 1 << 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_capture,
  input  logic                       req_readout,
  input  logic                       req_thumb,
  output logic                       cmd_capture,
  output logic                       cmd_readout,
  output logic                       cmd_thumb,
  input  logic                       status_captureDone,
  input  logic [PixelCountWidth-1:0] status_capturePixelCount,
  input  logic                       readout_ready,
  output logic                       readout_trigger,
  input  logic [15:0]                readout_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic                       done,
  output logic [1:0]                 err
);

  localparam int MaxWords = (FullWordCount > ThumbWordCount) ? FullWordCount : ThumbWordCount;
  localparam int MaxTo    = (CaptureTimeout > WordTimeout) ? CaptureTimeout : WordTimeout;
  localparam int RemW     = $clog2(MaxWords + 1);
  localparam int TmrW     = $clog2(MaxTo + 1);

  localparam logic [RemW-1:0]            FULL_CNT  = RemW'(FullWordCount);
  localparam logic [RemW-1:0]            THUMB_CNT = RemW'(ThumbWordCount);
  localparam logic [TmrW-1:0]            CAP_LAST  = TmrW'(CaptureTimeout - 1);
  localparam logic [TmrW-1:0]            WORD_LAST = TmrW'(WordTimeout - 1);
  localparam logic [PixelCountWidth-1:0] PIX_EXP   = PixelCountWidth'(PixelCount);

  typedef enum logic [2:0] {
    S_IDLE, S_CAP_WAIT, S_RD_ISSUE, S_RD_RUN, S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic            rd_q, rd_d;
  logic            thumb_q, thumb_d;
  logic            done_prev_q, done_prev_d;
  logic            cmd_capture_q, cmd_capture_d;
  logic            cmd_readout_q, cmd_readout_d;
  logic            cmd_thumb_q, cmd_thumb_d;
  logic            done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [TmrW-1:0] timer_q, timer_d, timer_inc;
  logic [RemW-1:0] remaining_q, remaining_d;
  logic            rd_run, have_words, word_acc;

  assign rd_run     = (state_q == S_RD_RUN);
  assign have_words = (remaining_q != '0);
  // A word moves only when the controller has one and downstream takes it,
  // so the controller-side and downstream-side handshakes always coincide.
  assign word_acc   = rd_run && have_words && readout_ready && out_ready;
  assign timer_inc  = (timer_q == {TmrW{1'b1}}) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    thumb_d       = thumb_q;
    done_prev_d   = done_prev_q;
    cmd_capture_d = cmd_capture_q;
    cmd_readout_d = cmd_readout_q;
    cmd_thumb_d   = cmd_thumb_q;
    done_d        = 1'b0;
    err_d         = err_q;
    timer_d       = timer_q;
    remaining_d   = remaining_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        rd_d    = req_readout;
        thumb_d = req_thumb;
        if (req_capture) begin
          cmd_capture_d = ~cmd_capture_q;
          // Snapshot the pre-issue level so a done toggle landing in the
          // very first CAP_WAIT cycle is still seen.
          done_prev_d   = status_captureDone;
          timer_d       = '0;
          state_d       = S_CAP_WAIT;
        end else if (req_readout) begin
          state_d = S_RD_ISSUE;
        end else begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          err_d   = 2'd0;
        end
      end
      S_CAP_WAIT: begin
        if (status_captureDone != done_prev_q) begin
          if (status_capturePixelCount != PIX_EXP) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            err_d   = 2'd2;
          end else if (rd_q) begin
            state_d = S_RD_ISSUE;
          end else begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            err_d   = 2'd0;
          end
        end else if (timer_q == CAP_LAST) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          err_d   = 2'd1;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RD_ISSUE: begin
        cmd_thumb_d   = thumb_q;
        cmd_readout_d = ~cmd_readout_q;
        remaining_d   = thumb_q ? THUMB_CNT : FULL_CNT;
        timer_d       = '0;
        state_d       = S_RD_RUN;
      end
      S_RD_RUN: begin
        if (word_acc) begin
          remaining_d = remaining_q - 1'b1;
          timer_d     = '0;
          if (remaining_q == RemW'(1)) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            err_d   = 2'd0;
          end
        end else if (timer_q == WORD_LAST) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          err_d   = 2'd3;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rd_q          <= 1'b0;
      thumb_q       <= 1'b0;
      done_prev_q   <= 1'b0;
      cmd_capture_q <= 1'b0;
      cmd_readout_q <= 1'b0;
      cmd_thumb_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 2'd0;
      timer_q       <= '0;
      remaining_q   <= '0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      thumb_q       <= thumb_d;
      done_prev_q   <= done_prev_d;
      cmd_capture_q <= cmd_capture_d;
      cmd_readout_q <= cmd_readout_d;
      cmd_thumb_q   <= cmd_thumb_d;
      done_q        <= done_d;
      err_q         <= err_d;
      timer_q       <= timer_d;
      remaining_q   <= remaining_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign cmd_capture     = cmd_capture_q;
  assign cmd_readout     = cmd_readout_q;
  assign cmd_thumb       = cmd_thumb_q;
  assign done            = done_q;
  assign err             = err_q;
  assign readout_trigger = rd_run && have_words && out_ready;
  assign out_valid       = rd_run && have_words && readout_ready;
  assign out_data        = readout_data;

endmodule

// File: tb/tb_img_sequencer.sv
module tb_img_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_capture = 1'b0, req_readout = 1'b0, req_thumb = 1'b0;
  logic        cmd_capture, cmd_readout, cmd_thumb;
  logic        status_captureDone = 1'b0;
  logic [21:0] status_capturePixelCount = '0;
  logic        readout_ready = 1'b0, readout_trigger;
  logic [15:0] readout_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_data;
  logic        done;
  logic [1:0]  err;

  img_sequencer #(
    .FullWordCount(64), .ThumbWordCount(16), .PixelCount(40),
    .PixelCountWidth(22), .CaptureTimeout(100), .WordTimeout(50)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_capture(req_capture), .req_readout(req_readout), .req_thumb(req_thumb),
    .cmd_capture(cmd_capture), .cmd_readout(cmd_readout), .cmd_thumb(cmd_thumb),
    .status_captureDone(status_captureDone),
    .status_capturePixelCount(status_capturePixelCount),
    .readout_ready(readout_ready), .readout_trigger(readout_trigger),
    .readout_data(readout_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] seed;

  // results of the last run_job
  int r_done_cyc, r_xfer, r_first, r_last, r_cap_tog, r_cap_cyc;
  int r_rd_tog, r_rd_tog_cyc, r_stat_cyc;
  logic [1:0] r_err;
  logic r_thumb;

  // Drives one job cycle by cycle, acting as the image controller and the
  // downstream consumer. Cycle 0 is the accept cycle. Controller words are
  // pushed to the scoreboard when first presented and popped on transfer.
  // Entered just after a rising edge; returns at the falling edge of the
  // done cycle (or after max_cyc).
  task automatic run_job(input logic cap, input logic rd, input logic th,
                         input int cap_delay, input logic [21:0] pix,
                         input int ctl_words, input int rdy_pct, input int max_cyc);
    logic pc, pr, armed;
    logic [15:0] exp;
    int ctl_idx, pushed;
    pc = cmd_capture; pr = cmd_readout; armed = 1'b0;
    ctl_idx = 0; pushed = 0;
    exp_q.delete();
    seed = 16'($urandom);
    r_done_cyc = -1; r_xfer = 0; r_first = -1; r_last = -1; r_cap_tog = 0; r_cap_cyc = -1;
    r_rd_tog = 0; r_rd_tog_cyc = -1; r_stat_cyc = -1; r_err = 2'd0; r_thumb = 1'b0;
    req_valid = 1'b1; req_capture = cap; req_readout = rd; req_thumb = th;
    readout_ready = 1'b0;
    out_ready = (rdy_pct >= 100);
    for (int cyc = 0; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL word: got %h at cycle %0d, none expected", out_data, cyc);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            n_err++;
            $display("FAIL word: got %h want %h at cycle %0d", out_data, exp, cyc);
          end
        end
        r_xfer++;
        if (r_first < 0) r_first = cyc;
        r_last = cyc;
      end
      if (readout_ready && readout_trigger) ctl_idx++;
      if (done) begin
        r_done_cyc = cyc; r_err = err; r_thumb = cmd_thumb;
        break;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (cmd_capture !== pc) begin pc = cmd_capture; r_cap_tog++; r_cap_cyc = cyc + 1; end
      if (cmd_readout !== pr) begin pr = cmd_readout; r_rd_tog++; r_rd_tog_cyc = cyc + 1; armed = 1'b1; end
      if (cap_delay >= 0 && r_cap_cyc >= 0 && cyc + 1 == r_cap_cyc + cap_delay) begin
        status_captureDone = ~status_captureDone;
        status_capturePixelCount = pix;
        r_stat_cyc = cyc + 1;
      end
      readout_ready = armed && (ctl_idx < ctl_words);
      readout_data  = seed + 16'(ctl_idx);
      if (readout_ready && ctl_idx >= pushed) begin
        exp_q.push_back(readout_data);
        pushed++;
      end
      out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
    end
    readout_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_vec++; if ({cmd_capture, cmd_readout, cmd_thumb} !== 3'b000) begin n_err++; $display("FAIL rst_cmds: got %b want 000", {cmd_capture, cmd_readout, cmd_thumb}); end
    n_vec++; if ({done, err, readout_trigger, out_valid} !== 5'b0) begin n_err++; $display("FAIL rst_outs: got %b want 00000", {done, err, readout_trigger, out_valid}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_job;
    logic saw_done;
    saw_done = 1'b0;
    req_valid = 1'b1; req_capture = 1'b1; req_readout = 1'b1; req_thumb = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    n_vec++; if ({req_ready, cmd_capture} !== 2'b01) begin n_err++; $display("FAIL midjob_wait: ready,cap got %b want 01", {req_ready, cmd_capture}); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({cmd_capture, cmd_readout, cmd_thumb} !== 3'b000) begin n_err++; $display("FAIL midjob_cmds: got %b want 000", {cmd_capture, cmd_readout, cmd_thumb}); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midjob_ready: got %b want 1", req_ready); end
    repeat (3) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL midjob_done: got done pulse, want none"); end
    @(posedge clk); #1;
  endtask

  // Tail shared by the job tests: done must drop and req_ready rise next cycle.
  task automatic finish_cycle(input string name);
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if ({done, req_ready} !== 2'b01) begin n_err++; $display("FAIL %s_after: done,ready got %b want 01", name, {done, req_ready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_capture_full;
    run_job(1'b1, 1'b1, 1'b0, 5, 22'd40, 64, 50, 3000);
    n_vec++; if (r_done_cyc < 0) begin n_err++; $display("FAIL full_done: no done within budget"); end
    n_vec++; if (r_err !== 2'd0) begin n_err++; $display("FAIL full_err: got %0d want 0", r_err); end
    n_vec++; if (r_xfer !== 64) begin n_err++; $display("FAIL full_count: got %0d want 64", r_xfer); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL full_left: %0d words left, want 0", exp_q.size()); end
    n_vec++; if (r_cap_cyc !== 1) begin n_err++; $display("FAIL full_cap_lat: toggle at %0d want 1", r_cap_cyc); end
    n_vec++; if (r_rd_tog !== 1) begin n_err++; $display("FAIL full_rd_tog: got %0d want 1", r_rd_tog); end
    n_vec++; if (r_rd_tog_cyc !== r_stat_cyc + 2) begin n_err++; $display("FAIL full_rd_lat: got %0d want %0d", r_rd_tog_cyc, r_stat_cyc + 2); end
    n_vec++; if (r_thumb !== 1'b0) begin n_err++; $display("FAIL full_thumb: got %b want 0", r_thumb); end
    n_vec++; if (r_done_cyc !== r_last + 1) begin n_err++; $display("FAIL full_done_lat: got %0d want %0d", r_done_cyc, r_last + 1); end
    finish_cycle("full");
  endtask

  task automatic test_thumb_only;
    run_job(1'b0, 1'b1, 1'b1, -1, 22'd0, 100, 100, 500);
    n_vec++; if (r_err !== 2'd0 || r_done_cyc < 0) begin n_err++; $display("FAIL thumb_err: got %0d (done cyc %0d) want 0", r_err, r_done_cyc); end
    n_vec++; if (r_xfer !== 16) begin n_err++; $display("FAIL thumb_count: got %0d want 16", r_xfer); end
    n_vec++; if (r_last - r_first !== 15) begin n_err++; $display("FAIL thumb_consec: span %0d want 15", r_last - r_first); end
    n_vec++; if (r_cap_tog !== 0) begin n_err++; $display("FAIL thumb_cap: got %0d toggles want 0", r_cap_tog); end
    n_vec++; if (r_thumb !== 1'b1) begin n_err++; $display("FAIL thumb_sel: got %b want 1", r_thumb); end
    n_vec++; if (r_done_cyc !== r_last + 1) begin n_err++; $display("FAIL thumb_done_lat: got %0d want %0d", r_done_cyc, r_last + 1); end
    finish_cycle("thumb");
  endtask

  task automatic test_pixel_mismatch;
    run_job(1'b1, 1'b1, 1'b0, 3, 22'd39, 64, 100, 500);
    n_vec++; if (r_err !== 2'd2 || r_done_cyc < 0) begin n_err++; $display("FAIL pix_err: got %0d (done cyc %0d) want 2", r_err, r_done_cyc); end
    n_vec++; if (r_rd_tog !== 0) begin n_err++; $display("FAIL pix_rd_tog: got %0d want 0", r_rd_tog); end
    finish_cycle("pix");
  endtask

  task automatic test_capture_only_same_cycle;
    // capture done toggles in the same cycle the capture command toggles
    run_job(1'b1, 1'b0, 1'b0, 0, 22'd40, 0, 100, 500);
    n_vec++; if (r_err !== 2'd0 || r_done_cyc !== 2) begin n_err++; $display("FAIL caponly: err %0d done cyc %0d want 0/2", r_err, r_done_cyc); end
    n_vec++; if (r_rd_tog !== 0) begin n_err++; $display("FAIL caponly_rd: got %0d want 0", r_rd_tog); end
    finish_cycle("caponly");
  endtask

  task automatic test_noop_back_to_back;
    run_job(1'b0, 1'b0, 1'b0, -1, 22'd0, 0, 100, 20);
    n_vec++; if (r_err !== 2'd0 || r_done_cyc !== 1) begin n_err++; $display("FAIL noop: err %0d done cyc %0d want 0/1", r_err, r_done_cyc); end
    @(posedge clk); #1;
    run_job(1'b0, 1'b0, 1'b0, -1, 22'd0, 0, 100, 20);
    n_vec++; if (r_done_cyc !== 1) begin n_err++; $display("FAIL b2b: done cyc %0d want 1", r_done_cyc); end
    finish_cycle("b2b");
  endtask

  task automatic test_capture_timeout;
    run_job(1'b1, 1'b1, 1'b0, -1, 22'd0, 64, 100, 300);
    n_vec++; if (r_done_cyc !== 101) begin n_err++; $display("FAIL captmo_lat: done cyc %0d want 101", r_done_cyc); end
    n_vec++; if (r_err !== 2'd1) begin n_err++; $display("FAIL captmo_err: got %0d want 1", r_err); end
    n_vec++; if (r_rd_tog !== 0) begin n_err++; $display("FAIL captmo_rd: got %0d want 0", r_rd_tog); end
    finish_cycle("captmo");
  endtask

  task automatic test_word_timeout;
    run_job(1'b0, 1'b1, 1'b0, -1, 22'd0, 10, 100, 500);
    n_vec++; if (r_xfer !== 10) begin n_err++; $display("FAIL wordtmo_count: got %0d want 10", r_xfer); end
    n_vec++; if (r_err !== 2'd3) begin n_err++; $display("FAIL wordtmo_err: got %0d want 3", r_err); end
    n_vec++; if (r_done_cyc !== r_last + 51) begin n_err++; $display("FAIL wordtmo_lat: done cyc %0d want %0d", r_done_cyc, r_last + 51); end
    finish_cycle("wordtmo");
  endtask

  initial begin
    test_reset();
    test_reset_mid_job();
    test_capture_full();
    test_thumb_only();
    test_pixel_mismatch();
    test_capture_only_same_cycle();
    test_noop_back_to_back();
    test_capture_timeout();
    test_word_timeout();
    test_capture_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
